// File: rtl/mips_multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback steps and drives every datapath select/enable.
module mips_multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic       IorD,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       AluSrcA,
    output logic [1:0] AluSrcB,
    output logic [1:0] AluOp,
    output logic [1:0] PCSrc,
    output logic [3:0] state,
    output logic       illegal_op
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BEQ    = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       w_legal;

    assign state = r_state;

    assign w_legal = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
                     (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);

    // Unsupported opcodes fall back to FETCH; PC already advanced in FETCH.
    assign illegal_op = !reset && (r_state == S_DECODE) && !w_legal;

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                if (op == OP_LW || op == OP_SW) w_next = S_MEMADR;
                else if (op == OP_RTYPE)        w_next = S_EXEC;
                else if (op == OP_BEQ)          w_next = S_BEQ;
                else if (op == OP_ADDI)         w_next = S_ADDIEX;
                else if (op == OP_J)            w_next = S_JUMP;
                else                            w_next = S_FETCH;
            end
            S_MEMADR: w_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = S_MEMWB;
            S_EXEC:   w_next = S_ALUWB;
            S_ADDIEX: w_next = S_ADDIWB;
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        PCWrite  = 1'b0;
        Branch   = 1'b0;
        IorD     = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        AluSrcA  = 1'b0;
        AluSrcB  = 2'b00;
        AluOp    = 2'b00;
        PCSrc    = 2'b00;
        case (r_state)
            S_FETCH: begin
                AluSrcB = 2'b01;
                IRWrite = 1'b1;
                PCWrite = 1'b1;
            end
            S_DECODE: AluSrcB = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                AluSrcA = 1'b1;
                AluSrcB = 2'b10;
            end
            S_MEMRD: IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXEC: begin
                AluSrcA = 1'b1;
                AluOp   = 2'b10;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BEQ: begin
                AluSrcA = 1'b1;
                AluOp   = 2'b01;
                PCSrc   = 2'b01;
                Branch  = 1'b1;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_JUMP: begin
                PCSrc   = 2'b10;
                PCWrite = 1'b1;
            end
            default: ;
        endcase
        // Reset presents idle FETCH selects with every write enable suppressed.
        if (reset) begin
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            PCWrite  = 1'b0;
            Branch   = 1'b0;
            IorD     = 1'b0;
            RegDst   = 1'b0;
            MemtoReg = 1'b0;
            AluSrcA  = 1'b0;
            AluSrcB  = 2'b01;
            AluOp    = 2'b00;
            PCSrc    = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: directed and random opcode streams checked
// cycle by cycle against an instruction-level reference model.
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       MemWrite, IRWrite, RegWrite, PCWrite, Branch;
    logic       IorD, RegDst, MemtoReg, AluSrcA, illegal_op;
    logic [1:0] AluSrcB, AluOp, PCSrc;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mips_multicycle_control dut (
        .clk(clk), .reset(reset), .op(op),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .PCWrite(PCWrite), .Branch(Branch), .IorD(IorD), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB),
        .AluOp(AluOp), .PCSrc(PCSrc), .state(state), .illegal_op(illegal_op)
    );

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BQ = 6'b000100, AI = 6'b001000, JP = 6'b000010;

    logic [15:0] obs;
    assign obs = {MemWrite, IRWrite, RegWrite, PCWrite, Branch, IorD, RegDst,
                  MemtoReg, AluSrcA, AluSrcB, AluOp, PCSrc, illegal_op};

    function automatic bit is_legal(input logic [5:0] o);
        return o inside {LW, SW, RT, BQ, AI, JP};
    endfunction

    // Step list an instruction walks through, FETCH first.
    function automatic void steps_for(input logic [5:0] o, output int q[$]);
        q = {};
        case (o)
            LW:      q = '{0, 1, 2, 3, 4};
            SW:      q = '{0, 1, 2, 5};
            RT:      q = '{0, 1, 6, 7};
            AI:      q = '{0, 1, 9, 10};
            BQ:      q = '{0, 1, 8};
            JP:      q = '{0, 1, 11};
            default: q = '{0, 1};
        endcase
    endfunction

    function automatic logic [15:0] expect_out(input int st, input logic [5:0] o,
                                               input logic rst);
        logic mw = 0, irw = 0, rw = 0, pcw = 0, br = 0, iord = 0, rdst = 0;
        logic m2r = 0, sa = 0, ill = 0;
        logic [1:0] sb = 2'b00, aop = 2'b00, pcs = 2'b00;
        if (rst) begin
            sb = 2'b01;
        end else begin
            if (st == 0) begin sb = 2'b01; irw = 1; pcw = 1; end
            if (st == 1) begin sb = 2'b11; ill = !is_legal(o); end
            if (st == 2 || st == 9) begin sa = 1; sb = 2'b10; end
            if (st == 3) iord = 1;
            if (st == 4) begin m2r = 1; rw = 1; end
            if (st == 5) begin iord = 1; mw = 1; end
            if (st == 6) begin sa = 1; aop = 2'b10; end
            if (st == 7) begin rdst = 1; rw = 1; end
            if (st == 8) begin sa = 1; aop = 2'b01; pcs = 2'b01; br = 1; end
            if (st == 10) rw = 1;
            if (st == 11) begin pcs = 2'b10; pcw = 1; end
        end
        return {mw, irw, rw, pcw, br, iord, rdst, m2r, sa, sb, aop, pcs, ill};
    endfunction

    task automatic check(input string tag, input int st, input logic [5:0] o,
                         input logic rst);
        logic [3:0] es;
        logic [15:0] eo;
        es = 4'(st);
        eo = expect_out(st, o, rst);
        total++;
        assert (state === es) else begin
            bad++;
            $error("FAIL %s state got=%0d exp=%0d", tag, state, es);
        end
        total++;
        assert (obs === eo) else begin
            bad++;
            $error("FAIL %s outputs(st=%0d op=%b) got=%b exp=%b", tag, st, o, obs, eo);
        end
    endtask

    // Entered just after an edge with the DUT in FETCH; leaves it the same way.
    task automatic run_instr(input string tag, input logic [5:0] o);
        int q[$];
        steps_for(o, q);
        foreach (q[i]) begin
            op = (q[i] == 1 || q[i] == 2) ? o : 6'($urandom);
            #1;
            check(tag, q[i], op, 1'b0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [5:0] rop;
        int q[$];
        reset = 1'b1;
        op    = 6'b0;
        repeat (3) begin
            @(posedge clk); #1;
            op = 6'($urandom);
            #1;
            check("reset_hold", 0, op, 1'b1);
        end
        reset = 1'b0;

        run_instr("lw", LW);
        run_instr("rtype", RT);
        run_instr("beq", BQ);
        run_instr("sw", SW);
        run_instr("addi", AI);
        run_instr("j", JP);
        run_instr("illegal", 6'b111111);

        // Abort a load in MEMRD: no writeback may follow.
        steps_for(LW, q);
        for (int i = 0; i < 3; i++) begin
            op = (q[i] == 1 || q[i] == 2) ? LW : 6'($urandom);
            #1;
            check("lw_pre_abort", q[i], op, 1'b0);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        op = 6'($urandom);
        #1;
        check("abort_memrd", 3, op, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        run_instr("after_abort", SW);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 7))
                0: rop = LW;
                1: rop = SW;
                2: rop = RT;
                3: rop = BQ;
                4: rop = AI;
                5: rop = JP;
                default: rop = 6'($urandom);
            endcase
            run_instr("random", rop);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
